// File: rtl/grid_slot_lsq_pkg.sv
// Shared types and constants for the grid PR-slot load/store queue.
// Provides the queue entry payload, FSM state encoding, funct3 codes and
// the request legality check used at enqueue time.
package grid_slot_lsq_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned BE_W              = XLEN / 8;
  localparam int unsigned LSQ_DEPTH_DEFAULT = 4;

  localparam logic [2:0] FN3_B  = 3'b000;
  localparam logic [2:0] FN3_H  = 3'b001;
  localparam logic [2:0] FN3_W  = 3'b010;
  localparam logic [2:0] FN3_BU = 3'b100;
  localparam logic [2:0] FN3_HU = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            is_store;
  } lsq_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } lsq_state_t;

  // Legal = exactly one of load/store, known size, no unsigned stores, natural alignment.
  function automatic logic req_legal(input logic [2:0] fn3, input logic [1:0] off,
                                     input logic ld, input logic st);
    logic ok;
    ok = (ld != st);
    case (fn3)
      FN3_B:   ok = ok;
      FN3_H:   ok = ok && !off[0];
      FN3_W:   ok = ok && (off == 2'b00);
      FN3_BU:  ok = ok && !st;
      FN3_HU:  ok = ok && !st && !off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/grid_slot_lsq_if.sv
// Slot-side load/store request bus.
// master: the PR slot (drives addr/data/fn3/load/store/new_request).
// slave:  the LSQ (drives lsq_full/load_data_out/load_data_valid).
interface grid_slot_lsq_if;
  import grid_slot_lsq_pkg::*;

  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] data;
  logic [2:0]      fn3;
  logic            load;
  logic            store;
  logic            new_request;
  logic            lsq_full;
  logic [XLEN-1:0] load_data_out;
  logic            load_data_valid;

  modport master (
    output addr, data, fn3, load, store, new_request,
    input  lsq_full, load_data_out, load_data_valid
  );

  modport slave (
    input  addr, data, fn3, load, store, new_request,
    output lsq_full, load_data_out, load_data_valid
  );

endinterface

// File: rtl/grid_slot_lsq_align.sv
// Combinational byte-lane logic.
// Store side: byte enables and lane-replicated write data from st_fn3/st_off.
// Load side:  shifts the read word down by ld_off bytes, then sign/zero-extends.
// Ports: st_fn3, st_off, st_data -> wdata_c, be_c; ld_fn3, ld_off, ld_rdata -> ldata_c.
module grid_slot_lsq_align
  import grid_slot_lsq_pkg::*;
(
  input  logic [2:0]      st_fn3,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  input  logic [2:0]      ld_fn3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] wdata_c,
  output logic [BE_W-1:0] be_c,
  output logic [XLEN-1:0] ldata_c
);

  logic [XLEN-1:0] shifted;

  // Size comes from fn3[1:0]; fn3[2] only selects unsigned extension.
  always_comb begin
    be_c    = '0;
    wdata_c = st_data;
    case (st_fn3[1:0])
      2'b00: begin
        be_c    = BE_W'(4'b0001 << st_off);
        wdata_c = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_c    = BE_W'(4'b0011 << st_off);
        wdata_c = {2{st_data[15:0]}};
      end
      default: begin
        be_c    = '1;
        wdata_c = st_data;
      end
    endcase
  end

  always_comb begin
    shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_fn3[1:0])
      2'b00:   ldata_c = ld_fn3[2] ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ldata_c = ld_fn3[2] ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: ldata_c = shifted;
    endcase
  end

endmodule

// File: rtl/grid_slot_lsq.sv
// In-order load/store queue between one PR slot and the data-memory arbiter.
// Ports: clk, rst (async, active-high); slot (grid_slot_lsq_if.slave);
// mem_req/mem_we/mem_addr/mem_wdata/mem_be out, mem_ack/mem_rvalid/mem_rdata in;
// protocol_err (sticky, set when an illegal or overflowing request is dropped).
module grid_slot_lsq
  import grid_slot_lsq_pkg::*;
#(
  parameter int unsigned LSQ_DEPTH = LSQ_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  grid_slot_lsq_if.slave  slot,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            protocol_err
);

  localparam int unsigned PW = $clog2(LSQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  lsq_entry_t      q [LSQ_DEPTH];
  lsq_entry_t      in_e;
  lsq_entry_t      head_e;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            full_q;
  lsq_state_t      state;
  lsq_state_t      state_nxt;
  logic            legal_c;
  logic            push_c;
  logic            pop_c;
  logic            issue_c;
  logic            capture_c;
  logic [2:0]      cur_fn3;
  logic [1:0]      cur_off;
  logic [XLEN-1:0] ldata_q;
  logic            ldv_q;
  logic [XLEN-1:0] wdata_c;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] ldata_c;

  assign in_e    = '{addr: slot.addr, data: slot.data, fn3: slot.fn3, is_store: slot.store};
  assign head_e  = q[head];
  assign legal_c = req_legal(slot.fn3, slot.addr[1:0], slot.load, slot.store);
  // full_q is the registered view of count, so a same-cycle pop never frees a slot for a push.
  assign push_c  = slot.new_request && !full_q && legal_c;

  assign slot.lsq_full        = full_q;
  assign slot.load_data_out   = ldata_q;
  assign slot.load_data_valid = ldv_q;

  grid_slot_lsq_align u_align (
    .st_fn3   (head_e.fn3),
    .st_off   (head_e.addr[1:0]),
    .st_data  (head_e.data),
    .ld_fn3   (cur_fn3),
    .ld_off   (cur_off),
    .ld_rdata (mem_rdata),
    .wdata_c  (wdata_c),
    .be_c     (be_c),
    .ldata_c  (ldata_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; a load acked together with its read data completes immediately.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = ISSUE;
      ISSUE:   if (mem_ack) state_nxt = (mem_we || mem_rvalid) ? IDLE : WAIT_RD;
      WAIT_RD: if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM strobes driving the datapath registers.
  always_comb begin
    issue_c   = 1'b0;
    pop_c     = 1'b0;
    capture_c = 1'b0;
    case (state)
      IDLE:    issue_c = (count != '0);
      ISSUE: begin
        pop_c     = mem_ack;
        capture_c = mem_ack && !mem_we && mem_rvalid;
      end
      WAIT_RD: capture_c = mem_rvalid;
      default: ;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c)      count_nxt = count + CW'(1);
    else if (!push_c && pop_c) count_nxt = count - CW'(1);
  end

  // Entry storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_c) q[tail] <= in_e;
  end

  // Pointers, occupancy, memory-side and slot-side output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      full_q       <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      cur_fn3      <= '0;
      cur_off      <= '0;
      ldata_q      <= '0;
      ldv_q        <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      count  <= count_nxt;
      full_q <= (count_nxt == CW'(LSQ_DEPTH));
      if (push_c) tail <= tail + PW'(1);
      if (pop_c) begin
        head    <= head + PW'(1);
        mem_req <= 1'b0;
      end
      if (issue_c) begin
        mem_req   <= 1'b1;
        mem_we    <= head_e.is_store;
        mem_addr  <= {head_e.addr[XLEN-1:2], 2'b00};
        mem_wdata <= wdata_c;
        mem_be    <= be_c;
        cur_fn3   <= head_e.fn3;
        cur_off   <= head_e.addr[1:0];
      end
      ldv_q <= capture_c;
      if (capture_c) ldata_q <= ldata_c;
      if (slot.new_request && !push_c) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grid_slot_lsq.sv
// Directed bench for grid_slot_lsq: table of single-request vectors with a
// responsive memory model, plus hand-written overflow, illegal-request and
// reset-during-read sequences.
module tb_grid_slot_lsq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack    = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;
  logic        protocol_err;

  int n_chk  = 0;
  int n_fail = 0;

  grid_slot_lsq_if slot_if ();

  grid_slot_lsq dut (
    .clk          (clk),
    .rst          (rst),
    .slot         (slot_if.slave),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        st;
    logic [2:0]  fn3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          ack_dly;
    logic        zw;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic [31:0] e_ldata;
  } vec_t;

  vec_t vt [9];

  function automatic vec_t mk(input logic st, input logic [2:0] fn3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] rdata, input int ack_dly,
                              input logic zw, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                              input logic [3:0] e_be, input logic [31:0] e_ldata);
    vec_t v;
    v.st = st; v.fn3 = fn3; v.addr = addr; v.data = data; v.rdata = rdata;
    v.ack_dly = ack_dly; v.zw = zw; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_be = e_be; v.e_ldata = e_ldata;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic send(input logic ld, input logic st, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d);
    slot_if.load        = ld;
    slot_if.store       = st;
    slot_if.fn3         = f;
    slot_if.addr        = a;
    slot_if.data        = d;
    slot_if.new_request = 1'b1;
    tick();
    slot_if.new_request = 1'b0;
    slot_if.load        = 1'b0;
    slot_if.store       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'h0);
    chk({tag, "_lsq_full"}, 32'(slot_if.lsq_full), 32'h0);
    chk({tag, "_ldv"}, 32'(slot_if.load_data_valid), 32'h0);
    chk({tag, "_ldata"}, slot_if.load_data_out, 32'h0);
    chk({tag, "_perr"}, 32'(protocol_err), 32'h0);
  endtask

  initial begin
    slot_if.addr = '0; slot_if.data = '0; slot_if.fn3 = '0;
    slot_if.load = 1'b0; slot_if.store = 1'b0; slot_if.new_request = 1'b0;

    vt[0] = mk(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0);
    vt[1] = mk(1'b1, 3'b000, 32'h103, 32'h5A, 32'h0, 0, 1'b0, 32'h100, 32'h5A5A5A5A, 4'b1000, 32'h0);
    vt[2] = mk(1'b0, 3'b000, 32'h103, 32'h0, 32'h5A000000, 1, 1'b0, 32'h100, 32'h0, 4'b1000, 32'h0000005A);
    vt[3] = mk(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 1'b0, 32'h100, 32'h0, 4'b1100, 32'hFFFF8001);
    vt[4] = mk(1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0, 1'b1, 32'h100, 32'h0, 4'b1100, 32'h00008001);
    vt[5] = mk(1'b0, 3'b100, 32'h101, 32'h0, 32'h0000FF00, 1, 1'b0, 32'h100, 32'h0, 4'b0010, 32'h000000FF);
    vt[6] = mk(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, 1'b0, 32'h200, 32'hABCDABCD, 4'b1100, 32'h0);
    vt[7] = mk(1'b0, 3'b010, 32'h204, 32'h0, 32'h13579BDF, 0, 1'b1, 32'h204, 32'h0, 4'b1111, 32'h13579BDF);
    vt[8] = mk(1'b0, 3'b000, 32'h100, 32'h0, 32'h000000F0, 0, 1'b0, 32'h100, 32'h0, 4'b0001, 32'hFFFFFFF0);

    // Reset values while reset is held.
    tick();
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Table-driven single transactions.
    for (int i = 0; i < 9; i++) begin
      send(!vt[i].st, vt[i].st, vt[i].fn3, vt[i].addr, vt[i].data);
      tick();
      chk($sformatf("v%0d_req_latency", i), 32'(mem_req), 32'h1);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vt[i].e_be));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].st));
      if (vt[i].st) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].e_wdata);
      for (int d = 0; d < vt[i].ack_dly; d++) begin
        tick();
        chk($sformatf("v%0d_req_hold%0d", i, d), 32'(mem_req), 32'h1);
        chk($sformatf("v%0d_addr_hold%0d", i, d), mem_addr, vt[i].e_addr);
      end
      mem_ack = 1'b1;
      if (!vt[i].st && vt[i].zw) begin
        mem_rvalid = 1'b1;
        mem_rdata  = vt[i].rdata;
      end
      tick();
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      chk($sformatf("v%0d_req_drop", i), 32'(mem_req), 32'h0);
      if (vt[i].st) begin
        chk($sformatf("v%0d_no_ldv", i), 32'(slot_if.load_data_valid), 32'h0);
      end else begin
        if (!vt[i].zw) begin
          chk($sformatf("v%0d_ldv_wait", i), 32'(slot_if.load_data_valid), 32'h0);
          mem_rvalid = 1'b1;
          mem_rdata  = vt[i].rdata;
          tick();
          mem_rvalid = 1'b0;
        end
        chk($sformatf("v%0d_ldv", i), 32'(slot_if.load_data_valid), 32'h1);
        chk($sformatf("v%0d_ldata", i), slot_if.load_data_out, vt[i].e_ldata);
      end
      tick();
      chk($sformatf("v%0d_ldv_end", i), 32'(slot_if.load_data_valid), 32'h0);
    end
    chk("table_perr", 32'(protocol_err), 32'h0);

    // Overflow: five back-to-back stores with memory stalled.
    do_reset();
    for (int k = 0; k < 4; k++) send(1'b0, 1'b1, 3'b010, 32'h40 + 32'(4 * k), 32'(k + 1));
    chk("full_after4", 32'(slot_if.lsq_full), 32'h1);
    chk("full_perr_before", 32'(protocol_err), 32'h0);
    send(1'b0, 1'b1, 3'b010, 32'h80, 32'h55);
    chk("full_perr", 32'(protocol_err), 32'h1);
    chk("full_still", 32'(slot_if.lsq_full), 32'h1);
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 0;
      while (!mem_req && w < 8) begin
        tick();
        w++;
      end
      chk($sformatf("drain%0d_req", k), 32'(mem_req), 32'h1);
      chk($sformatf("drain%0d_addr", k), mem_addr, 32'h40 + 32'(4 * k));
      chk($sformatf("drain%0d_wdata", k), mem_wdata, 32'(k + 1));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      if (k == 0) chk("drain_full_clear", 32'(slot_if.lsq_full), 32'h0);
    end
    tick(); tick(); tick();
    chk("drain_no_5th", 32'(mem_req), 32'h0);

    // Illegal requests are dropped without a memory request.
    do_reset();
    send(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
    tick(); tick(); tick();
    chk("ill_lw_mis_req", 32'(mem_req), 32'h0);
    chk("ill_lw_mis_perr", 32'(protocol_err), 32'h1);
    do_reset();
    chk("ill_perr_cleared", 32'(protocol_err), 32'h0);
    send(1'b1, 1'b1, 3'b010, 32'h100, 32'h0);
    tick(); tick(); tick();
    chk("ill_ldst_req", 32'(mem_req), 32'h0);
    chk("ill_ldst_perr", 32'(protocol_err), 32'h1);
    do_reset();
    send(1'b0, 1'b1, 3'b100, 32'h100, 32'h7);
    tick(); tick();
    chk("ill_sbu_req", 32'(mem_req), 32'h0);
    chk("ill_sbu_perr", 32'(protocol_err), 32'h1);

    // Reset while waiting for read data; late rvalid must be ignored.
    do_reset();
    send(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    chk("rwr_req", 32'(mem_req), 32'h1);
    chk("rwr_addr", mem_addr, 32'h300);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rwr");
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    tick();
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    chk("rwr_no_ldv", 32'(slot_if.load_data_valid), 32'h0);
    chk("rwr_ldata", slot_if.load_data_out, 32'h0);
    tick();
    chk("rwr_no_ldv2", 32'(slot_if.load_data_valid), 32'h0);
    chk("rwr_no_req", 32'(mem_req), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
